// File: rtl/muldiv_if.sv
// Handshake/data bundle between the control path and the iterative multiply/divide unit.
// The master drives the request and operands, the slave returns busy/done and the write-back fields.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            we;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, rd_in,
    input  busy, done, we, rd_out, result
  );

  modport slave (
    input  start, op, a, b, rd_in,
    output busy, done, we, rd_out, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per clock, fixed latency.
// Define MULDIV_SIGNED_EN to build the signed variants (MULH, MULHSU, DIV, REM); otherwise they run unsigned.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  localparam int ITER_W = $clog2(XLEN + 1);
  localparam logic [2:0] OP_MUL = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   result_q;
  logic [ITER_W-1:0] cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   dvs;

  logic              accept;
  logic              last;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_nx;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_df;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   quo_nx;
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   quo_f;
  logic [XLEN-1:0]   rem_f;
  logic [XLEN-1:0]   fin;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == RUN) && (cnt == ITER_W'(1));

`ifdef MULDIV_SIGNED_EN
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  logic a_neg, b_neg, neg_a, neg_b;

  // The core only ever sees magnitudes; the operand signs are remembered for the final fix-up.
  always_comb begin
    a_neg = bus.a[XLEN-1] && (bus.op == OP_MULH || bus.op == OP_MULHSU ||
                              bus.op == OP_DIV  || bus.op == OP_REM);
    b_neg = bus.b[XLEN-1] && (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM);
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else if (accept) begin
      neg_a <= a_neg;
      neg_b <= b_neg;
    end
  end

  // A zero divisor must still yield an all-ones quotient, so it is never negated.
  always_comb begin
    prod_f = (neg_a ^ neg_b) ? -acc_nx : acc_nx;
    quo_f  = ((neg_a ^ neg_b) && (dvs != '0)) ? -quo_nx : quo_nx;
    rem_f  = neg_a ? -rem_nx : rem_nx;
  end
`else
  assign a_mag  = bus.a;
  assign b_mag  = bus.b;
  assign prod_f = acc_nx;
  assign quo_f  = quo_nx;
  assign rem_f  = rem_nx;
`endif

  // Both cores step every RUN cycle; only the one selected by op_q feeds the result.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
    acc_nx  = {mul_sum, acc[XLEN-1:1]};
    rem_sh  = {rem, quo[XLEN-1]};
    rem_ge  = (rem_sh >= {1'b0, dvs});
    rem_df  = rem_sh - {1'b0, dvs};
    rem_nx  = XLEN'(rem_ge ? rem_df : rem_sh);
    quo_nx  = {quo[XLEN-2:0], rem_ge};
  end

  always_comb begin
    fin = rem_f;
    case (op_q)
      OP_MUL:                  fin = prod_f[XLEN-1:0];
      3'b001, 3'b010, 3'b011:  fin = prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:          fin = quo_f;
      default:                 fin = rem_f;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (cnt == ITER_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      rd_q     <= '0;
      result_q <= '0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
    end else if (accept) begin
      op_q <= bus.op;
      rd_q <= bus.rd_in;
      cnt  <= ITER_W'(XLEN);
      acc  <= {{XLEN{1'b0}}, a_mag};
      rem  <= '0;
      quo  <= a_mag;
      dvs  <= b_mag;
    end else if (state == RUN) begin
      cnt <= cnt - ITER_W'(1);
      acc <= acc_nx;
      rem <= rem_nx;
      quo <= quo_nx;
      if (last) result_q <= fin;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.we     = (state == DONE);
  assign bus.rd_out = rd_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, start-while-busy and mid-operation reset.
// Expected values follow the build: define MULDIV_SIGNED_EN here as well for the signed variant.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          doneCyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   nChecks = 0;
  int   nFail = 0;
  exp_t sb[$];
  exp_t mon;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Drives a request at a negedge; the expected response is queued once the accepting edge has passed.
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] expRes, output int startCyc);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    startCyc  = cyc;
    sb.push_back('{expRes, rd, cyc + XLEN, name});
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) return;
    end
    checkOutput({name, ".idle_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic waitCyc(input int target);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cyc == target) return;
    end
    checkOutput("cycle_wait_timeout", 32'(cyc), 32'(target));
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expRes);
    int sc;
    applyStimulus(name, op, a, b, rd, expRes, sc);
    waitIdle(name);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation, including its cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL unexpected_done: got done=1 with result 0x%08h, expected no pulse",
                   bus.result);
        end else begin
          mon = sb.pop_front();
          checkOutput({mon.name, ".result"}, bus.result, mon.res);
          checkOutput({mon.name, ".rd_out"}, 32'(bus.rd_out), 32'(mon.rd));
          checkOutput({mon.name, ".we"}, 32'(bus.we), 32'd1);
          checkOutput({mon.name, ".done_cycle"}, 32'(cyc), 32'(mon.doneCyc));
        end
      end
    end
  end

  initial begin
    int base;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.rd_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.done", 32'(bus.done), 32'd0);
    checkOutput("reset.we", 32'(bus.we), 32'd0);
    checkOutput("reset.rd_out", 32'(bus.rd_out), 32'd0);
    checkOutput("reset.result", bus.result, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // MUL 7*6 with start pulses in cycle 5 and in the DONE cycle 33, then a start accepted in cycle 34.
    applyStimulus("mul_7x6", OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, base);
    waitCyc(base + 4);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1; bus.b = 32'd1; bus.rd_in = 5'd31;
    @(negedge clk);
    bus.start = 1'b0;
    waitCyc(base + 32);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1; bus.b = 32'd1; bus.rd_in = 5'd30;
    @(negedge clk);
    applyStimulus("mul_after_done", OP_MUL, 32'h1234, 32'h10, 5'd3, 32'h0001_2340, base);
    checkOutput("accept_cycle34.busy", 32'(bus.busy), 32'd1);
    waitIdle("mul_after_done");

    runOp("mulhu_ones", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
    runOp("mul_ones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001);
    runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd4, 32'd14);
    runOp("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2);
    runOp("divu_by0", OP_DIVU, 32'd9, 32'd0, 5'd8, 32'hFFFF_FFFF);
    runOp("remu_by0", OP_REMU, 32'd9, 32'd0, 5'd9, 32'd9);
    runOp("div_by0_neg", OP_DIV, 32'hFFFF_FFF7, 32'd0, 5'd10, 32'hFFFF_FFFF);
    runOp("rem_by0_neg", OP_REM, 32'hFFFF_FFF7, 32'd0, 5'd11, 32'hFFFF_FFF7);
`ifdef MULDIV_SIGNED_EN
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD);
    runOp("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFF);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    runOp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0);
    runOp("mulh_m1_m1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'd0);
    runOp("mulhsu_m1_2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd18, 32'hFFFF_FFFF);
`else
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'h7FFF_FFFC);
    runOp("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'd1);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);
    runOp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
    runOp("mulh_m1_m1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE);
    runOp("mulhsu_m1_2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd18, 32'd1);
`endif
    runOp("mulhu_big", OP_MULHU, 32'h8000_0000, 32'd6, 5'd19, 32'd3);

    // DIVU aborted by reset in cycle 10: everything clears at once and no done pulse follows.
    runOp("remu_pre_reset", OP_REMU, 32'd1000, 32'd7, 5'd20, 32'd6);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3; bus.rd_in = 5'd12;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    base = cyc;
    waitCyc(base + 9);
    rst = 1'b0;
    #1;
    checkOutput("abort.busy", 32'(bus.busy), 32'd0);
    checkOutput("abort.done", 32'(bus.done), 32'd0);
    checkOutput("abort.we", 32'(bus.we), 32'd0);
    checkOutput("abort.result", bus.result, 32'd0);
    checkOutput("abort.rd_out", 32'(bus.rd_out), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("abort.busy_after_release", 32'(bus.busy), 32'd0);
    runOp("mul_3x4", OP_MUL, 32'd3, 32'd4, 5'd7, 32'd12);

    if (sb.size() != 0) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending results, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
